scatter_feed_queue: RTL and testbench

//   Multi-push / multi-pop circular queue directly upstream of scatter. Buffers DATA-wide entries,

---
 rtl/scatter_feed_queue_pkg.sv | 35 +++
 rtl/scatter_feed_queue_if.sv | 41 ++++
 rtl/scatter_feed_queue_window_mux.sv | 54 +++++
 rtl/scatter_feed_queue.sv | 121 ++++++++++++
 tb/tb_scatter_feed_queue.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/scatter_feed_queue_pkg.sv
// ============================================================================
// Module : scatter_feed_queue_pkg
// Brief  : Shared defaults, width helpers and valid-polarity levels for the
//          scatter feed path (queue, scatter and their benches).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scatter_feed_queue_pkg;

    localparam int DATA_DEF  = 32;
    localparam int IN_DEF    = 8;
    localparam int DEPTH_DEF = 16;
    localparam bit ACT_DEF   = 1'b1;

    // Width of a count that can hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic lvl_enable(input bit act);
        return act;
    endfunction

    function automatic logic lvl_disable(input bit act);
        return ~act;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scatter_feed_queue_if.sv
// ============================================================================
// Module : scatter_feed_queue_if
// Brief  : Push/pop and window bundle between the feed queue (slave) and its
//          producer/consumer side (master).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface scatter_feed_queue_if
    import scatter_feed_queue_pkg::*;
#(
    parameter int DATA  = DATA_DEF,
    parameter int IN    = IN_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CNT = cnt_w(IN);
    localparam int OCC = occ_w(DEPTH);

    logic [CNT-1:0]     push_cnt;
    logic [IN*DATA-1:0] push_data;
    logic [CNT-1:0]     pop_cnt;
    logic [IN*DATA-1:0] win_data;
    logic [IN-1:0]      win_valid;
    logic [OCC-1:0]     free_cnt;
    logic               empty;
    logic               full;
    logic               err;

    modport master (
        output push_cnt, push_data, pop_cnt,
        input  win_data, win_valid, free_cnt, empty, full, err
    );

    modport slave (
        input  push_cnt, push_data, pop_cnt,
        output win_data, win_valid, free_cnt, empty, full, err
    );

endinterface

`default_nettype wire

// File: rtl/scatter_feed_queue_window_mux.sv
// ============================================================================
// Module : scatter_feed_queue_window_mux
// Brief  : Packs the oldest entries (and any same-cycle bypass lanes) into an
//          aligned window with a thermometer valid vector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scatter_feed_queue_window_mux
    import scatter_feed_queue_pkg::*;
#(
    parameter int DATA  = DATA_DEF,
    parameter int IN    = IN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter bit ACT   = ACT_DEF
)(
    input  wire logic [$clog2(DEPTH)-1:0] head,
    input  wire logic [cnt_w(IN)-1:0]     stored_cnt,
    input  wire logic [cnt_w(IN)-1:0]     vis_cnt,
    input  wire logic [DATA-1:0]          mem [DEPTH],
    input  wire logic [IN*DATA-1:0]       push_data,
    output logic      [IN*DATA-1:0]       win_data,
    output logic      [IN-1:0]            win_valid
);

    localparam int CNT = cnt_w(IN);
    localparam int PTR = $clog2(DEPTH);

    logic [PTR-1:0] w_idx;
    int             w_lane;

    always_comb begin
        win_data  = '0;
        win_valid = {IN{lvl_disable(ACT)}};
        w_idx     = '0;
        w_lane    = 0;
        for (int i = 0; i < IN; i++) begin
            w_idx = head + PTR'(i);
            if (CNT'(i) < stored_cnt) begin
                win_data[i*DATA +: DATA] = mem[w_idx];
            end else if (CNT'(i) < vis_cnt) begin
                // Lanes past the stored entries come straight from this cycle's push.
                w_lane = i - int'(stored_cnt);
                win_data[i*DATA +: DATA] = push_data[w_lane*DATA +: DATA];
            end
            if (CNT'(i) < vis_cnt) begin
                win_valid[i] = lvl_enable(ACT);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/scatter_feed_queue.sv
// ============================================================================
// Module : scatter_feed_queue
// Brief  : Multi-push / multi-pop circular queue presenting its oldest IN
//          entries as an aligned window for scatter. Optional same-cycle
//          bypass enabled by defining SCATTER_FEED_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scatter_feed_queue
    import scatter_feed_queue_pkg::*;
#(
    parameter int DATA  = DATA_DEF,
    parameter int IN    = IN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter bit ACT   = ACT_DEF
)(
    input  wire logic           clk,
    input  wire logic           reset,
    scatter_feed_queue_if.slave feed
);

    localparam int CNT = cnt_w(IN);
    localparam int OCC = occ_w(DEPTH);
    localparam int PTR = $clog2(DEPTH);
    // One spare bit so occ + push never overflows before the limit checks.
    localparam int SW  = OCC + 1;
    localparam logic [SW-1:0] C_IN_W    = SW'(IN);
    localparam logic [SW-1:0] C_DEPTH_W = SW'(DEPTH);

    logic [PTR-1:0]  r_head;
    logic [OCC-1:0]  r_occ;
    logic            r_err;
    logic [DATA-1:0] r_mem [DEPTH];

    logic [SW-1:0]   w_occ;
    logic [SW-1:0]   w_free;
    logic [SW-1:0]   w_push;
    logic [SW-1:0]   w_pop;
    logic [SW-1:0]   w_push_eff;
    logic [SW-1:0]   w_pop_eff;
    logic [SW-1:0]   w_stored;
    logic [SW-1:0]   w_vis;
    logic [SW-1:0]   w_skip;
    logic            w_push_bad;
    logic            w_pop_bad;
    logic [IN-1:0]   w_we;
    logic [PTR-1:0]  w_waddr [IN];

    always_comb begin
        w_occ      = SW'(r_occ);
        w_free     = C_DEPTH_W - w_occ;
        w_push     = SW'(feed.push_cnt);
        w_pop      = SW'(feed.pop_cnt);
        w_push_bad = (w_push > C_IN_W) || (w_push > w_free);
        w_push_eff = w_push_bad ? '0 : w_push;
        w_stored   = (w_occ < C_IN_W) ? w_occ : C_IN_W;
`ifdef SCATTER_FEED_BYPASS_EN
        w_vis      = ((w_occ + w_push_eff) < C_IN_W) ? (w_occ + w_push_eff) : C_IN_W;
`else
        w_vis      = w_stored;
`endif
        w_pop_bad  = w_pop > w_vis;
        w_pop_eff  = w_pop_bad ? w_vis : w_pop;
`ifdef SCATTER_FEED_BYPASS_EN
        // Pushed entries consumed through the bypass never reach storage.
        w_skip     = (w_pop_eff > w_occ) ? (w_pop_eff - w_occ) : '0;
`else
        w_skip     = '0;
`endif
        for (int k = 0; k < IN; k++) begin
            w_we[k]    = (SW'(k) < w_push_eff) && (SW'(k) >= w_skip);
            w_waddr[k] = PTR'(SW'(r_head) + w_occ + SW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_occ  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_head <= r_head + PTR'(w_pop_eff);
            r_occ  <= OCC'(w_occ - w_pop_eff + w_push_eff);
            r_err  <= r_err | w_push_bad | w_pop_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < IN; k++) begin
                if (w_we[k]) begin
                    r_mem[w_waddr[k]] <= feed.push_data[k*DATA +: DATA];
                end
            end
        end
    end

    scatter_feed_queue_window_mux #(
        .DATA  (DATA),
        .IN    (IN),
        .DEPTH (DEPTH),
        .ACT   (ACT)
    ) u_window_mux (
        .head       (r_head),
        .stored_cnt (CNT'(w_stored)),
        .vis_cnt    (CNT'(w_vis)),
        .mem        (r_mem),
        .push_data  (feed.push_data),
        .win_data   (feed.win_data),
        .win_valid  (feed.win_valid)
    );

    assign feed.free_cnt = OCC'(w_free);
    assign feed.empty    = (r_occ == '0);
    assign feed.full     = (r_occ == OCC'(DEPTH));
    assign feed.err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_scatter_feed_queue.sv
// ============================================================================
// Module : tb_scatter_feed_queue
// Brief  : Directed and random stimulus against a queue-based reference of
//          the feed queue; honours SCATTER_FEED_BYPASS_EN when defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scatter_feed_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    scatter_feed_queue_if #(.DATA(32), .IN(8), .DEPTH(16)) ifc ();

    scatter_feed_queue #(.DATA(32), .IN(8), .DEPTH(16), .ACT(1'b1)) dut (
        .clk   (clk),
        .reset (rst),
        .feed  (ifc)
    );

    // Reference: a plain FIFO of entries plus a sticky error bit.
    logic [31:0] mq[$];
    logic        merr = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int vis_of(input int occ, input int pe);
`ifdef SCATTER_FEED_BYPASS_EN
        return (occ + pe < 8) ? occ + pe : 8;
`else
        return (occ < 8) ? occ : 8;
`endif
    endfunction

    function automatic int push_eff_of(input int occ, input int pc);
        return (pc <= 8 && pc <= 16 - occ) ? pc : 0;
    endfunction

    int m_occ, m_pc, m_pe, m_pop, m_vis;
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            merr = 1'b0;
        end else begin
            m_occ = mq.size();
            m_pc  = int'(ifc.push_cnt);
            m_pop = int'(ifc.pop_cnt);
            m_pe  = push_eff_of(m_occ, m_pc);
            if (m_pe != m_pc) merr = 1'b1;
            m_vis = vis_of(m_occ, m_pe);
            if (m_pop > m_vis) begin
                merr  = 1'b1;
                m_pop = m_vis;
            end
            for (int k = 0; k < m_pe; k++) mq.push_back(ifc.push_data[k*32 +: 32]);
            repeat (m_pop) void'(mq.pop_front());
        end
    end

    int          c_occ, c_pe, c_vis;
    logic [255:0] c_ew;
    logic [7:0]   c_ev;
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            c_occ = mq.size();
            c_pe  = push_eff_of(c_occ, int'(ifc.push_cnt));
            c_vis = vis_of(c_occ, c_pe);
            c_ew  = '0;
            c_ev  = '0;
            for (int i = 0; i < 8; i++) begin
                if (i < c_vis) begin
                    c_ev[i] = 1'b1;
                    c_ew[i*32 +: 32] = (i < c_occ) ? mq[i] : ifc.push_data[(i-c_occ)*32 +: 32];
                end
            end
            chk("win_data",  ifc.win_data, c_ew);
            chk("win_valid", 256'(ifc.win_valid), 256'(c_ev));
            chk("free_cnt",  256'(ifc.free_cnt), 256'(16 - c_occ));
            chk("empty",     256'(ifc.empty), 256'(c_occ == 0));
            chk("full",      256'(ifc.full), 256'(c_occ == 16));
            chk("err",       256'(ifc.err), 256'(merr));
        end
    end

    function automatic logic [31:0] lane(input int i);
        return ifc.win_data[i*32 +: 32];
    endfunction

    task automatic drive(input int pc, input logic [31:0] base, input int pop);
        @(negedge clk);
        ifc.push_cnt = 4'(pc);
        for (int k = 0; k < 8; k++) ifc.push_data[k*32 +: 32] = base + 32'(k);
        ifc.pop_cnt = 4'(pop);
    endtask

    task automatic idle();
        @(negedge clk);
        ifc.push_cnt  = '0;
        ifc.push_data = '0;
        ifc.pop_cnt   = '0;
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifc.push_cnt = '0;
        ifc.pop_cnt  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.push_cnt  = '0;
        ifc.push_data = '0;
        ifc.pop_cnt   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #3;
        chk("t1_valid", 256'(ifc.win_valid), 256'(0));
        chk("t1_free",  256'(ifc.free_cnt), 256'(16));
        chk("t1_empty", 256'(ifc.empty), 256'(1));
        chk("t1_full",  256'(ifc.full), 256'(0));
        chk("t1_err",   256'(ifc.err), 256'(0));

        drive(3, 32'hA0, 0);
        idle();
        chk("t2_valid", 256'(ifc.win_valid), 256'(8'h07));
        chk("t2_lane0", 256'(lane(0)), 256'(32'hA0));
        chk("t2_lane2", 256'(lane(2)), 256'(32'hA2));
        chk("t2_lane3", 256'(lane(3)), 256'(0));
        chk("t2_free",  256'(ifc.free_cnt), 256'(13));
        drive(0, 0, 3);

        drive(8, 32'h100, 0);
        drive(8, 32'h200, 0);
        idle();
        chk("t3_full_pre", 256'(ifc.full), 256'(1));
        chk("t3_err_pre",  256'(ifc.err), 256'(0));
        drive(1, 32'h300, 0);
        idle();
        chk("t3_full",  256'(ifc.full), 256'(1));
        chk("t3_err",   256'(ifc.err), 256'(1));
        chk("t3_lane0", 256'(lane(0)), 256'(32'h100));
        chk("t3_lane7", 256'(lane(7)), 256'(32'h107));
        do_reset();

        drive(5, 32'h10, 0);
        drive(4, 32'h20, 2);
        idle();
        chk("t4_free",  256'(ifc.free_cnt), 256'(9));
        chk("t4_valid", 256'(ifc.win_valid), 256'(8'h7f));
        chk("t4_lane0", 256'(lane(0)), 256'(32'h12));
        chk("t4_lane3", 256'(lane(3)), 256'(32'h20));
        drive(0, 0, 7);
        drive(5, 32'h0, 0);
        drive(0, 0, 5);

        drive(4, 32'h50, 0);
        idle();
        chk("t5_valid", 256'(ifc.win_valid), 256'(8'h0f));
        chk("t5_lane0", 256'(lane(0)), 256'(32'h50));
        chk("t5_lane3", 256'(lane(3)), 256'(32'h53));
        drive(0, 0, 4);
        idle();
        chk("t5_empty", 256'(ifc.empty), 256'(1));
        chk("t5_err",   256'(ifc.err), 256'(0));

        drive(3, 32'h60, 2);
        #3;
`ifdef SCATTER_FEED_BYPASS_EN
        chk("t6_byp_valid", 256'(ifc.win_valid), 256'(8'h07));
        chk("t6_byp_lane0", 256'(lane(0)), 256'(32'h60));
        idle();
        chk("t6_err",   256'(ifc.err), 256'(0));
        chk("t6_free",  256'(ifc.free_cnt), 256'(15));
        chk("t6_lane0", 256'(lane(0)), 256'(32'h62));
`else
        chk("t6_byp_valid", 256'(ifc.win_valid), 256'(8'h00));
        idle();
        chk("t6_err",   256'(ifc.err), 256'(1));
        chk("t6_free",  256'(ifc.free_cnt), 256'(13));
        chk("t6_lane0", 256'(lane(0)), 256'(32'h60));
`endif
        do_reset();

        drive(9, 32'h70, 0);
        idle();
        chk("t7_err",   256'(ifc.err), 256'(1));
        chk("t7_empty", 256'(ifc.empty), 256'(1));
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 499) do_reset();
            @(negedge clk);
            ifc.push_cnt = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 49) == 0) ifc.push_cnt = 4'd9;
            for (int k = 0; k < 8; k++) ifc.push_data[k*32 +: 32] = $urandom;
            ifc.pop_cnt = 4'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) ifc.pop_cnt = 4'($urandom_range(7, 9));
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
